// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the byte-stream instruction memory loader.
package imem_loader_pkg;

  localparam int MAX_WORDS_DEFAULT = 4000;
  localparam int BYTES_PER_WORD    = 4;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CSUM,
    DONE,
    ERROR
  } state_e;

  // Only the framing states take bytes from the host.
  function automatic logic accepts_bytes(state_e s);
    return s inside {LEN_HI, LEN_LO, DATA, CSUM};
  endfunction

endpackage

// File: rtl/imem_loader_byte_word_packer.sv
// Packs big-endian stream bytes into 32-bit words and pulses word_complete_o
// for one cycle after the fourth byte of each word is accepted.
module byte_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic        last_byte_o,
  output logic [31:0] word_o,
  output logic        word_complete_o
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      shift_q;
  logic             complete_q;

  assign last_byte_o     = accept_i && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));
  assign word_o          = shift_q;
  assign word_complete_o = complete_q;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      shift_q    <= '0;
      complete_q <= 1'b0;
    end else begin
      complete_q <= last_byte_o;
      if (clear_i) begin
        cnt_q   <= '0;
        shift_q <= '0;
      end else if (accept_i) begin
        cnt_q   <= cnt_q + 1'b1;
        shift_q <= {shift_q[23:0], byte_i};
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a framed byte stream (length, big-endian words, XOR checksum) into
// instruction memory, holding the CPU until the load completes cleanly.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int MAX_WORDS = MAX_WORDS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  state_e            state_q;
  logic [15:0]       count_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        csum_q;
  logic              hold_q;
  logic              done_q;
  logic              err_q;

  logic        xfer;
  logic        start_go;
  logic        data_xfer;
  logic        last_byte;
  logic        last_word;
  logic        word_complete;
  logic [15:0] count_full;
  logic [31:0] packed_word;

  assign byte_ready = accepts_bytes(state_q);
  assign xfer       = byte_valid && byte_ready;
  assign start_go   = start && (state_q inside {IDLE, DONE, ERROR});
  assign data_xfer  = xfer && (state_q == DATA);
  assign count_full = {count_q[15:8], byte_data};
  // addr_q still indexes the word being assembled: its predecessor's write
  // retired at least three cycles before this word's last byte can arrive.
  assign last_word  = (32'(addr_q) == 32'(count_q) - 32'd1);

  byte_word_packer u_packer (
    .clk             (clk),
    .rst             (rst),
    .clear_i         (start_go),
    .accept_i        (data_xfer),
    .byte_i          (byte_data),
    .last_byte_o     (last_byte),
    .word_o          (packed_word),
    .word_complete_o (word_complete)
  );

  assign wr_en     = word_complete;
  assign wr_addr   = addr_q;
  assign wr_data   = packed_word;
  assign cpu_hold  = hold_q;
  assign load_done = done_q;
  assign load_err  = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      addr_q  <= '0;
      csum_q  <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (word_complete) addr_q <= addr_q + 1'b1;
      case (state_q)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state_q <= LEN_HI;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            csum_q  <= '0;
            addr_q  <= '0;
          end
        end
        LEN_HI: begin
          if (xfer) begin
            count_q[15:8] <= byte_data;
            state_q       <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (xfer) begin
            count_q[7:0] <= byte_data;
            if ({16'd0, count_full} > 32'(MAX_WORDS)) begin
              state_q <= ERROR;
              err_q   <= 1'b1;
            end else if (count_full == 16'd0) begin
              state_q <= CSUM;
            end else begin
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            csum_q <= csum_q ^ byte_data;
            if (last_byte && last_word) state_q <= CSUM;
          end
        end
        CSUM: begin
          if (xfer) begin
            if (byte_data == csum_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
            end else begin
              state_q <= ERROR;
              err_q   <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected writes, a
// monitor pops and compares on every wr_en strobe.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] stream[$];
  int         checks   = 0;
  int         failures = 0;

  imem_loader #(.ADDR_W(12), .MAX_WORDS(4000)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (!rst && wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr %h data %h expected none", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e.addr));
        check("wr_data", wr_data, e.data);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit ok = 1'b0;
    byte_data  = b;
    byte_valid = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      if (byte_ready) begin
        @(posedge clk);
        ok = 1'b1;
      end
      @(negedge clk);
    end
    byte_valid = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL byte_timeout: byte %h not accepted, expected accept within 50 cycles", b);
    end
    if (gap) @(negedge clk);
  endtask

  task automatic send_stream(input logic [7:0] bs[$], input bit gap);
    foreach (bs[i]) send_byte(bs[i], gap);
  endtask

  task automatic check_flags(input string tag, input logic done, input logic err, input logic hold);
    check({tag, "_load_done"}, 32'(load_done), 32'(done));
    check({tag, "_load_err"},  32'(load_err),  32'(err));
    check({tag, "_cpu_hold"},  32'(cpu_hold),  32'(hold));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_flags("reset", 1'b0, 1'b0, 1'b0);
    check("reset_byte_ready", 32'(byte_ready), 32'd0);
    check("reset_wr_en", 32'(wr_en), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Two-word load with good checksum.
    pulse_start();
    check("t1_hold_after_start", 32'(cpu_hold), 32'd1);
    check("t1_ready_after_start", 32'(byte_ready), 32'd1);
    exp_q.push_back('{addr: 12'd0, data: 32'h20090002});
    exp_q.push_back('{addr: 12'd1, data: 32'h00094820});
    stream = '{8'h00, 8'h02, 8'h20, 8'h09, 8'h00, 8'h02, 8'h00, 8'h09, 8'h48, 8'h20, 8'h4A};
    send_stream(stream, 1'b0);
    repeat (2) @(negedge clk);
    check_flags("t1", 1'b1, 1'b0, 1'b0);
    check("t1_ready_done", 32'(byte_ready), 32'd0);

    // Same stream, bad checksum: words still written.
    pulse_start();
    check("t2_done_cleared", 32'(load_done), 32'd0);
    exp_q.push_back('{addr: 12'd0, data: 32'h20090002});
    exp_q.push_back('{addr: 12'd1, data: 32'h00094820});
    stream = '{8'h00, 8'h02, 8'h20, 8'h09, 8'h00, 8'h02, 8'h00, 8'h09, 8'h48, 8'h20, 8'h4B};
    send_stream(stream, 1'b0);
    repeat (2) @(negedge clk);
    check_flags("t2", 1'b0, 1'b1, 1'b1);

    // Oversize count 4001.
    pulse_start();
    check("t3_err_cleared", 32'(load_err), 32'd0);
    stream = '{8'h0F, 8'hA1};
    send_stream(stream, 1'b0);
    check("t3_ready_error", 32'(byte_ready), 32'd0);
    check_flags("t3", 1'b0, 1'b1, 1'b1);
    repeat (4) @(negedge clk);

    // Zero-length load.
    pulse_start();
    stream = '{8'h00, 8'h00, 8'h00};
    send_stream(stream, 1'b0);
    repeat (2) @(negedge clk);
    check_flags("t4", 1'b1, 1'b0, 1'b0);

    // One word with byte_valid toggling every cycle.
    pulse_start();
    exp_q.push_back('{addr: 12'd0, data: 32'h12345678});
    stream = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    send_stream(stream, 1'b1);
    repeat (2) @(negedge clk);
    check_flags("t5", 1'b1, 1'b0, 1'b0);

    // Reset after two data bytes, then a clean reload.
    pulse_start();
    stream = '{8'h00, 8'h01, 8'h12, 8'h34};
    send_stream(stream, 1'b0);
    rst = 1'b1;
    #1;
    check_flags("t6_rst", 1'b0, 1'b0, 1'b0);
    check("t6_rst_ready", 32'(byte_ready), 32'd0);
    check("t6_rst_wr_en", 32'(wr_en), 32'd0);
    check("t6_rst_wr_addr", 32'(wr_addr), 32'd0);
    check("t6_rst_wr_data", wr_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse_start();
    exp_q.push_back('{addr: 12'd0, data: 32'hAABBCCDD});
    stream = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
    send_stream(stream, 1'b0);
    repeat (2) @(negedge clk);
    check_flags("t6", 1'b1, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
